// File: rtl/ram_sdp_bytewe.sv
// Simple-dual-port RAM with a byte-enabled write port and a registered read port.
// A built-in sequencer zero-fills the array after reset or when clr_i is pulsed.
module ram_sdp_bytewe #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 32,
  parameter int BYPASS        = 1,
  parameter int INIT_ON_RESET = 1,
  localparam int NB = DATA_W / 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  output logic              busy_o,
  input  logic [NB-1:0]     we_i,
  input  logic [AW-1:0]     wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic              re_i,
  input  logic [AW-1:0]     ra_i,
  output logic [DATA_W-1:0] rd_o,
  output logic              rvalid_o
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic acceptPorts;
  logic waInRange;
  logic raInRange;

  // A clear request in IDLE takes priority over any access in the same cycle.
  assign acceptPorts = (state_q == IDLE) && !clr_i;
  assign waInRange   = (32'(wa_i) < DEPTH);
  assign raInRange   = (32'(ra_i) < DEPTH);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clr_i) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_d     = '0;
    rvalid_d = 1'b0;
    if (acceptPorts && re_i) begin
      rvalid_d = 1'b1;
      if (raInRange) begin
        rd_d = mem_q[ra_i];
        if ((BYPASS != 0) && (wa_i == ra_i)) begin
          for (int k = 0; k < NB; k++) begin
            if (we_i[k]) begin
              rd_d[8*k +: 8] = wd_i[8*k +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= (INIT_ON_RESET != 0) ? CLEAR : IDLE;
      ptr_q    <= '0;
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rd_q     <= rd_d;
      rvalid_q <= rvalid_d;
    end
  end

  // The array itself is deliberately left out of reset; only the sequencer clears it.
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem_q[ptr_q] <= '0;
    end else if (acceptPorts && waInRange) begin
      for (int k = 0; k < NB; k++) begin
        if (we_i[k]) begin
          mem_q[wa_i][8*k +: 8] <= wd_i[8*k +: 8];
        end
      end
    end
  end

  assign busy_o   = (state_q == CLEAR);
  assign rd_o     = rd_q;
  assign rvalid_o = rvalid_q;

endmodule
